// File: rtl/placement_cost_eval.sv
// placement_cost_eval: walks an edge list, fetches both endpoint positions and
// accumulates Manhattan cost, 2-hop-per-cycle cost and the longest edge.
// Each edge takes a fixed 8 cycles: read edge, fetch A, fetch B, compute, accumulate.
module placement_cost_eval #(
  parameter int unsigned W          = 32,
  parameter int unsigned N_EDGE_MAX = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [W-1:0]        n_edge,
  output logic                reEA,
  output logic                reEB,
  output logic [W-1:0]        addrEA,
  output logic [W-1:0]        addrEB,
  input  logic [W-1:0]        doutEA,
  input  logic [W-1:0]        doutEB,
  output logic                rePX,
  output logic                rePY,
  output logic [W-1:0]        addrPX,
  output logic [W-1:0]        addrPY,
  input  logic signed [W-1:0] doutPX,
  input  logic signed [W-1:0] doutPY,
  output logic                busy,
  output logic                done,
  output logic signed [W-1:0] sum,
  output logic signed [W-1:0] sum_1hop,
  output logic [W-1:0]        max_dist,
  output logic                error
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_EDGE, S_WAIT_E, S_RD_A, S_WAIT_A,
    S_RD_B, S_WAIT_B, S_CALC, S_ACC, S_DONE
  } state_t;

  // All-ones is the "unplaced" marker (-1 in two's complement).
  localparam logic [W-1:0] LP_UNPLACED = '1;
  localparam logic [W-1:0] LP_N_MAX    = W'(N_EDGE_MAX);

  state_t       r_state;
  logic [W-1:0] r_n;
  logic [W-1:0] r_i;
  logic [W-1:0] r_b;
  logic [W-1:0] r_ax;
  logic [W-1:0] r_ay;
  logic [W-1:0] r_dx;
  logic [W-1:0] r_dy;
  logic         r_skip;

  logic [W-1:0] w_n_clamp;
  logic [W-1:0] w_diff_x;
  logic [W-1:0] w_diff_y;
  logic [W-1:0] w_abs_x;
  logic [W-1:0] w_abs_y;
  logic [W-1:0] w_dist;
  logic [W-1:0] w_hop;
  logic [W-1:0] w_sum_next;
  logic [W-1:0] w_hop_next;
  logic         w_unplaced;
  logic         w_last;

  // Datapath: clamp, absolute differences, per-edge costs and accumulator updates.
  always_comb begin
    w_n_clamp  = (n_edge > LP_N_MAX) ? LP_N_MAX : n_edge;
    w_diff_x   = r_ax - $unsigned(doutPX);
    w_diff_y   = r_ay - $unsigned(doutPY);
    w_abs_x    = w_diff_x[W-1] ? (~w_diff_x + W'(1)) : w_diff_x;
    w_abs_y    = w_diff_y[W-1] ? (~w_diff_y + W'(1)) : w_diff_y;
    w_unplaced = (r_ax == LP_UNPLACED) || (r_ay == LP_UNPLACED) ||
                 ($unsigned(doutPX) == LP_UNPLACED) ||
                 ($unsigned(doutPY) == LP_UNPLACED);
    w_dist     = r_dx + r_dy;
    // ceil(d/2) as (d>>1)+lsb so a large d cannot overflow.
    w_hop      = (r_dx >> 1) + W'(r_dx[0]) + (r_dy >> 1) + W'(r_dy[0]);
    w_sum_next = $unsigned(sum) + w_dist - W'(1);
    w_hop_next = $unsigned(sum_1hop) + w_hop - W'(1);
    w_last     = ((r_i + W'(1)) == r_n);
  end

  // Control FSM with registered memory strobes and results.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_n      <= '0;
      r_i      <= '0;
      r_b      <= '0;
      r_ax     <= '0;
      r_ay     <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_skip   <= 1'b0;
      reEA     <= 1'b0;
      reEB     <= 1'b0;
      rePX     <= 1'b0;
      rePY     <= 1'b0;
      addrEA   <= '0;
      addrEB   <= '0;
      addrPX   <= '0;
      addrPY   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      sum_1hop <= '0;
      max_dist <= '0;
      error    <= 1'b0;
    end else begin
      reEA <= 1'b0;
      reEB <= 1'b0;
      rePX <= 1'b0;
      rePY <= 1'b0;
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            sum      <= '0;
            sum_1hop <= '0;
            max_dist <= '0;
            error    <= 1'b0;
            r_i      <= '0;
            r_n      <= w_n_clamp;
            busy     <= 1'b1;
            if (w_n_clamp == '0) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_RD_EDGE;
            end
          end
        end
        S_RD_EDGE: begin
          reEA    <= 1'b1;
          reEB    <= 1'b1;
          addrEA  <= r_i;
          addrEB  <= r_i;
          r_state <= S_WAIT_E;
        end
        S_WAIT_E: r_state <= S_RD_A;
        S_RD_A: begin
          r_b     <= doutEB;
          rePX    <= 1'b1;
          rePY    <= 1'b1;
          addrPX  <= doutEA;
          addrPY  <= doutEA;
          r_state <= S_WAIT_A;
        end
        S_WAIT_A: r_state <= S_RD_B;
        S_RD_B: begin
          r_ax    <= $unsigned(doutPX);
          r_ay    <= $unsigned(doutPY);
          rePX    <= 1'b1;
          rePY    <= 1'b1;
          addrPX  <= r_b;
          addrPY  <= r_b;
          r_state <= S_WAIT_B;
        end
        S_WAIT_B: r_state <= S_CALC;
        S_CALC: begin
          r_dx   <= w_abs_x;
          r_dy   <= w_abs_y;
          r_skip <= w_unplaced;
          if (w_unplaced) begin
            error <= 1'b1;
          end
          r_state <= S_ACC;
        end
        S_ACC: begin
          if (!r_skip) begin
            sum      <= $signed(w_sum_next);
            sum_1hop <= $signed(w_hop_next);
            if (w_dist > max_dist) begin
              max_dist <= w_dist;
            end
          end
          r_i <= r_i + W'(1);
          if (w_last) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_RD_EDGE;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_placement_cost_eval.sv
// Bench for placement_cost_eval: directed cases plus randomized edge lists,
// compared against a plain-arithmetic cost model over the same memory contents.
module tb_placement_cost_eval;
  localparam int unsigned W    = 32;
  localparam int unsigned NMAX = 5;

  logic                clk = 1'b0;
  logic                reset, start;
  logic [W-1:0]        n_edge;
  logic                reEA, reEB, rePX, rePY;
  logic [W-1:0]        addrEA, addrEB, addrPX, addrPY;
  logic [W-1:0]        doutEA, doutEB;
  logic signed [W-1:0] doutPX, doutPY;
  logic                busy, done, error;
  logic signed [W-1:0] sum, sum_1hop;
  logic [W-1:0]        max_dist;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mem_ea [16];
  logic [W-1:0] mem_eb [16];
  logic [W-1:0] mem_px [32];
  logic [W-1:0] mem_py [32];

  always #5 clk = ~clk;

  placement_cost_eval #(.W(W), .N_EDGE_MAX(NMAX)) dut (
    .clk(clk), .reset(reset), .start(start), .n_edge(n_edge),
    .reEA(reEA), .reEB(reEB), .addrEA(addrEA), .addrEB(addrEB),
    .doutEA(doutEA), .doutEB(doutEB),
    .rePX(rePX), .rePY(rePY), .addrPX(addrPX), .addrPY(addrPY),
    .doutPX(doutPX), .doutPY(doutPY),
    .busy(busy), .done(done), .sum(sum), .sum_1hop(sum_1hop),
    .max_dist(max_dist), .error(error)
  );

  // 1-cycle-latency memories; output is garbage whenever not read, so stale reuse is caught.
  always @(posedge clk) begin
    doutEA <= reEA ? mem_ea[addrEA[3:0]] : W'($urandom);
    doutEB <= reEB ? mem_eb[addrEB[3:0]] : W'($urandom);
    doutPX <= rePX ? $signed(mem_px[addrPX[4:0]]) : $signed(W'($urandom));
    doutPY <= rePY ? $signed(mem_py[addrPY[4:0]]) : $signed(W'($urandom));
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int eff_n(input int n);
    return (n > int'(NMAX)) ? int'(NMAX) : n;
  endfunction

  // Cost model: straight from the definitions, using wide integers then wrapping to W bits.
  task automatic model(input int n, output logic [W-1:0] e_sum, output logic [W-1:0] e_hop,
                       output logic [W-1:0] e_max, output logic e_err);
    longint s = 0, h = 0, m = 0;
    e_err = 1'b0;
    for (int k = 0; k < eff_n(n); k++) begin
      int a, b, ax, ay, bx, by;
      longint dx, dy;
      a  = int'(mem_ea[k][4:0]);
      b  = int'(mem_eb[k][4:0]);
      ax = int'(mem_px[a]); ay = int'(mem_py[a]);
      bx = int'(mem_px[b]); by = int'(mem_py[b]);
      if (ax == -1 || ay == -1 || bx == -1 || by == -1) begin
        e_err = 1'b1;
      end else begin
        dx = (ax > bx) ? longint'(ax - bx) : longint'(bx - ax);
        dy = (ay > by) ? longint'(ay - by) : longint'(by - ay);
        s += dx + dy - 1;
        h += (dx + 1) / 2 + (dy + 1) / 2 - 1;
        if (dx + dy > m) m = dx + dy;
      end
    end
    e_sum = W'(s);
    e_hop = W'(h);
    e_max = W'(m);
  endtask

  // Present start/n_edge for one edge; returns just after the accepting edge (cycle 0 end).
  task automatic launch(input int n, input bit hold);
    @(posedge clk);
    #1;
    start  = 1'b1;
    n_edge = W'(n);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Observe cycles 1..8n+2 of a run and compare timing and results with the model.
  task automatic watch(input string tag, input int n);
    int ne, last, dcyc, dcnt, re_cnt;
    logic [W-1:0] o_sum, o_hop, o_max, e_sum, e_hop, e_max;
    logic o_err, e_err;
    ne = eff_n(n); last = 8 * ne + 2;
    dcyc = 0; dcnt = 0; re_cnt = 0;
    o_sum = '0; o_hop = '0; o_max = '0; o_err = 1'b0;
    model(n, e_sum, e_hop, e_max, e_err);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (reEA || reEB || rePX || rePY) re_cnt++;
      if (done) begin
        dcnt++;
        if (dcyc == 0) begin
          dcyc = c;
          o_sum = $unsigned(sum); o_hop = $unsigned(sum_1hop);
          o_max = max_dist; o_err = error;
        end
      end
      if (c == 1 && ne > 0) begin
        chk({tag, "_busy_first"}, W'(busy), W'(1));
        chk({tag, "_sum_cleared"}, $unsigned(sum), '0);
      end
      if (c == 8 * ne && ne > 0) chk({tag, "_busy_last"}, W'(busy), W'(1));
      if (c == last) chk({tag, "_busy_after"}, W'(busy), W'(0));
    end
    chk({tag, "_done_cycle"}, W'(dcyc), W'(8 * ne + 1));
    chk({tag, "_done_count"}, W'(dcnt), W'(1));
    chk({tag, "_sum"}, o_sum, e_sum);
    chk({tag, "_sum_1hop"}, o_hop, e_hop);
    chk({tag, "_max_dist"}, o_max, e_max);
    chk({tag, "_error"}, W'(o_err), W'(e_err));
    if (ne == 0) chk({tag, "_no_reads"}, W'(re_cnt), W'(0));
  endtask

  task automatic set_node(input int k, input int x, input int y);
    mem_px[k] = W'(x);
    mem_py[k] = W'(y);
  endtask

  task automatic set_edge(input int k, input int a, input int b);
    mem_ea[k] = W'(a);
    mem_eb[k] = W'(b);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, W'(busy), W'(0));
    chk({tag, "_done"}, W'(done), W'(0));
    chk({tag, "_re"}, W'({reEA, reEB, rePX, rePY}), W'(0));
    chk({tag, "_addr"}, addrEA | addrEB | addrPX | addrPY, '0);
    chk({tag, "_sum"}, $unsigned(sum), '0);
    chk({tag, "_sum_1hop"}, $unsigned(sum_1hop), '0);
    chk({tag, "_max_dist"}, max_dist, '0);
    chk({tag, "_error"}, W'(error), W'(0));
  endtask

  initial begin
    int n, dcnt;
    reset = 1'b1; start = 1'b0; n_edge = '0;
    for (int k = 0; k < 16; k++) set_edge(k, 0, 0);
    for (int k = 0; k < 32; k++) set_node(k, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;

    // Single edge (0,0)-(2,3)
    set_node(0, 0, 0); set_node(1, 2, 3); set_edge(0, 0, 1);
    launch(1, 1'b0); watch("single", 1);

    // Empty run
    launch(0, 1'b0); watch("empty", 0);

    // Adjacent edge then long edge
    set_node(6, 1, 1); set_node(7, 1, 2); set_node(8, 0, 0); set_node(9, 5, 5);
    set_edge(0, 6, 7); set_edge(1, 8, 9);
    launch(2, 1'b0); watch("two", 2);

    // Unplaced endpoint is skipped and flagged
    set_node(2, 3, 4); set_node(3, -1, 7); set_node(4, 0, 0); set_node(5, 0, 1);
    set_edge(0, 2, 3); set_edge(1, 4, 5);
    launch(2, 1'b0); watch("unplaced", 2);

    // n_edge above the maximum is clamped
    for (int k = 0; k < 16; k++) set_edge(k, k, k + 1);
    launch(200, 1'b0); watch("clamp", 200);

    // Randomized edge lists
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 32; k++)
        set_node(k, ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 300)),
                 ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 300)));
      for (int k = 0; k < 16; k++)
        set_edge(k, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      n = int'($urandom_range(1, 7));
      launch(n, 1'b0); watch("random", n);
    end

    // Reset in cycle 5 of a 3-edge run aborts with no done
    set_node(10, 0, 0); set_node(11, 4, 4); set_node(12, 9, 1);
    set_edge(0, 10, 11); set_edge(1, 11, 12); set_edge(2, 12, 10);
    launch(3, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle_zero("abort");
    dcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", W'(dcnt), W'(0));
    launch(3, 1'b0); watch("after_abort", 3);

    // start held high: ignored while busy, then re-run reproduces the same results
    launch(3, 1'b1); watch("held_first", 3);
    @(posedge clk);
    #1;
    watch("held_second", 3);
    start = 1'b0;

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/placement_cost_eval.md
PLACEMENT_COST_EVAL -- requirements
Module: placement_cost_eval

Interface
REQ-001 Parameter W, default 32: data and address width of every memory port and result output.
REQ-002 Parameter N_EDGE_MAX, default 128: largest legal n_edge value.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Ports SHALL be as follows:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  run request, sampled in IDLE only
- n_edge  in  W  number of edges to evaluate, sampled with start
- reEA, reEB  out  1  edge-list ROM read enables
- addrEA, addrEB  out  W  edge-list read address
- doutEA, doutEB  in  W  edge endpoint node ids a and b
- rePX, rePY  out  1  position RAM read enables
- addrPX, addrPY  out  W  position RAM read address (node id)
- doutPX, doutPY  in  W signed  node X and Y coordinates; -1 means unplaced
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- sum  out  W signed  total Manhattan cost
- sum_1hop  out  W signed  total 2-hop-per-cycle cost
- max_dist  out  W  largest per-edge dx+dy seen
- error  out  1  sticky flag: an unplaced endpoint was found

Function
REQ-005 All memories SHALL be treated as 1-cycle read latency: dout is valid the cycle after re is high, and is not relied on in any later cycle.
REQ-006 FSM states SHALL be IDLE, RD_EDGE, WAIT_E, RD_A, WAIT_A, RD_B, WAIT_B, CALC, ACC, DONE.
REQ-007 IDLE with start=1: the block SHALL clear sum, sum_1hop, max_dist, error and edge index i, latch n_edge, and go to RD_EDGE. If the latched n_edge is 0 it SHALL go to DONE instead.
REQ-008 RD_EDGE SHALL assert reEA and reEB with address i; WAIT_E follows.
REQ-009 RD_A SHALL latch a and b, then assert rePX and rePY with address a; WAIT_A follows.
REQ-010 RD_B SHALL latch ax and ay from dout, then assert rePX and rePY with address b; WAIT_B follows.
REQ-011 CALC SHALL compute dx=|ax-doutPX| and dy=|ay-doutPY| into registers. If any of ax, ay, bx, by equals -1, it SHALL set error and mark the edge skipped.
REQ-012 ACC for a non-skipped edge SHALL apply:
- sum += dx+dy-1
- sum_1hop += ceil(dx/2)+ceil(dy/2)-1
- max_dist = max(max_dist, dx+dy)
ACC SHALL then increment i. If i+1==n_edge it SHALL go to DONE, otherwise to RD_EDGE.
REQ-013 Each edge SHALL take exactly 8 cycles. With start accepted in cycle 0, done SHALL be high in cycle 8*n_edge+1 only.
REQ-014 DONE SHALL pulse done for one cycle, drop busy, and return to IDLE. Results SHALL hold until the next accepted start.
REQ-015 Arithmetic SHALL be W-bit two's complement with wrap-around and no saturation. Absolute value SHALL be computed as invert-plus-one.
REQ-016 start SHALL be ignored while busy=1, including in the DONE cycle.
REQ-017 All read enables SHALL be low in every state not listed above. Addresses SHALL hold their last value.
REQ-018 n_edge greater than N_EDGE_MAX SHALL be clamped to N_EDGE_MAX.

Reset
REQ-019 While reset=1 at a clock edge, the block SHALL go to IDLE and set all of the following to 0: busy, done, all re outputs, all addresses, sum, sum_1hop, max_dist, error, i.
REQ-020 Reset asserted mid-run SHALL abort the run with no done pulse. The next start SHALL run from edge 0.

Verification
REQ-021 Single edge, n_edge=1, a=(0,0), b=(2,3) -> sum=4, sum_1hop=2, max_dist=5, error=0, done in cycle 9.
REQ-022 n_edge=0 -> done in cycle 1, all results 0, no memory read enable asserted.
REQ-023 Two edges, adjacent (1,1)-(1,2) and (0,0)-(5,5) -> sum=0+9=9, sum_1hop=0+5=5, max_dist=10, done in cycle 17.
REQ-024 Edge with PX[b]=-1, plus one valid edge (0,0)-(0,1) -> error=1, sum=0, sum_1hop=0, max_dist=1.
REQ-025 reset pulsed in cycle 5 of a 3-edge run -> the next cycle shows busy=0, all results 0, and no done pulse.
REQ-026 start held high throughout a run -> start is ignored while busy. After done, the new run clears results and reproduces the identical values.
